// File: rtl/mdio_pkg.sv
// Shared codes, FSM states and frame bit positions for the MDIO Clause-22/45 receptor.
package mdio_pkg;

    // Start-of-frame codes
    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] ST_C45 = 2'b00;

    // Opcodes
    localparam logic [1:0] OP_C22_WR = 2'b01;
    localparam logic [1:0] OP_C22_RD = 2'b10;
    localparam logic [1:0] OP_C45_AD = 2'b00;
    localparam logic [1:0] OP_C45_WR = 2'b01;
    localparam logic [1:0] OP_C45_RD = 2'b11;
    localparam logic [1:0] OP_C45_RI = 2'b10;

    // Bit index (k) of the last bit of each field, counted from ST's first bit
    localparam logic [4:0] K_OP_END  = 5'd3;
    localparam logic [4:0] K_PHY_END = 5'd8;
    localparam logic [4:0] K_REG_END = 5'd13;
    localparam logic [4:0] K_TA0     = 5'd14;
    localparam logic [4:0] K_TA1     = 5'd15;
    localparam logic [4:0] K_LAST    = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TA,
        S_DATA,
        S_SKIP
    } state_e;

    // True for an ST/OP pair this receptor understands
    function automatic logic code_ok(input logic [1:0] st, input logic [1:0] op,
                                     input logic c45_en);
        if (st == ST_C22) return (op == OP_C22_WR) || (op == OP_C22_RD);
        if (st == ST_C45) return c45_en;
        return 1'b0;
    endfunction

endpackage

// File: rtl/mdio_shreg.sv
// 16-bit shift register: serial capture of incoming bits, parallel load of read
// data, MSB-first serial out for driving the read response.
module mdio_shreg (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        shift_i,
    input  logic        ser_i,
    output logic [14:0] par_o,
    output logic        ser_o
);

    logic [15:0] sr_q;

    // Load has priority so the read word is never disturbed on its load edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     sr_q <= '0;
        else if (load_i)  sr_q <= load_val_i;
        else if (shift_i) sr_q <= {sr_q[14:0], ser_i};
    end

    assign par_o = sr_q[14:0];
    assign ser_o = sr_q[15];

endmodule

// File: rtl/receptor_mdio_c45.sv
// MDIO management-frame receptor (Clause 22 and Clause 45), clocked by MDC.
module receptor_mdio_c45
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR     = 5'd0,
    parameter int         PREAMBLE_LEN = 32,
    parameter bit         C45_EN       = 1'b1,
    parameter int         ADDR_W       = 16
) (
    input  logic              mdc_i,
    input  logic              rst_n_i,
    input  logic              mdio_out_i,
    input  logic [15:0]       rd_data_i,
    output logic              mdio_in_o,
    output logic              mdio_oe_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [4:0]        devad_o,
    output logic [15:0]       wr_data_o,
    output logic              wr_stb_o,
    output logic              rd_stb_o,
    output logic              mdio_done_o,
    output logic              frame_err_o
);

    localparam logic [5:0] PRE_N = 6'(PREAMBLE_LEN);

    state_e              state_q, state_d;
    logic [4:0]          k_q, k_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [1:0]          st_q, st_d, op_q, op_d;
    logic [4:0]          regad_q, regad_d;
    logic                ta0_q, ta0_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [4:0]          devad_q, devad_d;
    logic [15:0]         wd_q, wd_d;
    logic                oe_q, oe_d, min_q, min_d;
    logic                wr_q, wr_d, rd_q, rd_d, done_q, done_d, err_q, err_d;

    logic                sr_load, sr_msb;
    logic [14:0]         sr_par;
    logic [3:0]          code4;
    logic [4:0]          hdr5;
    logic [15:0]         data16;
    logic                is_c45, is_rd;

    // Every incoming bit is shifted in; the read word overwrites it at TA
    mdio_shreg u_shreg (
        .clk_i      (mdc_i),
        .rst_n_i    (rst_n_i),
        .load_i     (sr_load),
        .load_val_i (rd_data_i),
        .shift_i    (1'b1),
        .ser_i      (mdio_out_i),
        .par_o      (sr_par),
        .ser_o      (sr_msb)
    );

    // Field views including the bit being sampled on this edge
    assign code4  = {sr_par[2:0], mdio_out_i};
    assign hdr5   = {sr_par[3:0], mdio_out_i};
    assign data16 = {sr_par, mdio_out_i};
    assign is_c45 = (st_q == ST_C45);
    assign is_rd  = is_c45 ? (op_q == OP_C45_RD || op_q == OP_C45_RI) : (op_q == OP_C22_RD);

    // Next-state and output decode; strobes default low so each lasts one cycle
    always_comb begin
        state_d = state_q;  k_d = k_q;        cnt_d = cnt_q;
        st_d    = st_q;     op_d = op_q;      regad_d = regad_q;  ta0_d = ta0_q;
        addr_d  = addr_q;   devad_d = devad_q; wd_d = wd_q;
        oe_d    = oe_q;     min_d = min_q;
        wr_d = 1'b0; rd_d = 1'b0; done_d = 1'b0; err_d = 1'b0;
        sr_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mdio_out_i) begin
                    if (cnt_q != 6'd32) cnt_d = cnt_q + 6'd1;
                end else begin
                    cnt_d = '0;
                    if (cnt_q >= PRE_N) begin
                        state_d = S_HDR;
                        k_d     = 5'd1;
                    end
                end
            end
            S_HDR: begin
                k_d = k_q + 5'd1;
                if (k_q == K_OP_END) begin
                    st_d = code4[3:2];
                    op_d = code4[1:0];
                    if (!code_ok(code4[3:2], code4[1:0], C45_EN)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (k_q == K_PHY_END && hdr5 != PHY_ADDR) begin
                    state_d = S_SKIP;
                end else if (k_q == K_REG_END) begin
                    regad_d = hdr5;
                    state_d = S_TA;
                    if (is_rd) begin
                        rd_d = 1'b1;
                        // Clause-22 read presents its register address with the request
                        if (!is_c45) begin
                            addr_d  = ADDR_W'(hdr5);
                            devad_d = '0;
                        end
                    end
                end
            end
            S_TA: begin
                k_d = k_q + 5'd1;
                if (k_q == K_TA0) begin
                    ta0_d = mdio_out_i;
                    if (is_rd) begin
                        sr_load = 1'b1;
                        oe_d    = 1'b1;
                        min_d   = 1'b0;
                    end
                end else if (k_q == K_TA1) begin
                    state_d = S_DATA;
                    if (is_rd) begin
                        min_d = sr_msb;
                    end else if (!(ta0_q && !mdio_out_i)) begin
                        err_d   = 1'b1;
                        state_d = S_SKIP;
                    end
                end
            end
            S_DATA: begin
                k_d = k_q + 5'd1;
                if (is_rd) min_d = sr_msb;
                if (k_q == K_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                    min_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!is_c45) begin
                        if (!is_rd) begin
                            addr_d  = ADDR_W'(regad_q);
                            devad_d = '0;
                            wd_d    = data16;
                            wr_d    = 1'b1;
                        end
                    end else begin
                        case (op_q)
                            OP_C45_AD: begin
                                addr_d  = data16[ADDR_W-1:0];
                                devad_d = regad_q;
                            end
                            OP_C45_WR: begin
                                wd_d = data16;
                                wr_d = 1'b1;
                            end
                            OP_C45_RI: addr_d = addr_q + ADDR_W'(1);
                            default: ;
                        endcase
                    end
                end
            end
            S_SKIP: begin
                k_d = k_q + 5'd1;
                if (k_q == K_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge mdc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE; k_q <= '0; cnt_q <= '0;
            st_q <= '0; op_q <= '0; regad_q <= '0; ta0_q <= 1'b0;
            addr_q <= '0; devad_q <= '0; wd_q <= '0;
            oe_q <= 1'b0; min_q <= 1'b0;
            wr_q <= 1'b0; rd_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
        end else begin
            state_q <= state_d; k_q <= k_d; cnt_q <= cnt_d;
            st_q <= st_d; op_q <= op_d; regad_q <= regad_d; ta0_q <= ta0_d;
            addr_q <= addr_d; devad_q <= devad_d; wd_q <= wd_d;
            oe_q <= oe_d; min_q <= min_d;
            wr_q <= wr_d; rd_q <= rd_d; done_q <= done_d; err_q <= err_d;
        end
    end

    assign mdio_in_o   = min_q;
    assign mdio_oe_o   = oe_q;
    assign addr_o      = addr_q;
    assign devad_o     = devad_q;
    assign wr_data_o   = wd_q;
    assign wr_stb_o    = wr_q;
    assign rd_stb_o    = rd_q;
    assign mdio_done_o = done_q;
    assign frame_err_o = err_q;

endmodule
